// File: rtl/matvec_result_collector.sv
// Collects matvec_multiplier accumulators, requantizes each to DATA_WIDTH fixed point
// and packs BANDWIDTH lanes per word onto a valid/ready output for write-back.
module matvec_result_collector #(
  parameter int MAX_ROWS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_ROWS):0]         num_rows,
  input  logic signed [2*DATA_WIDTH-1:0]    result_in,
  input  logic                              result_valid,
  output logic [DATA_WIDTH*BANDWIDTH-1:0]   out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(BANDWIDTH):0]        out_count,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow_err
);

  localparam int DW  = DATA_WIDTH;
  localparam int BW  = BANDWIDTH;
  localparam int NRW = $clog2(MAX_ROWS) + 1;
  localparam int LW  = $clog2(BANDWIDTH);
  localparam int CW  = LW + 1;
  localparam int SW  = 2 * DATA_WIDTH + 1;

  localparam logic [LW-1:0]    LANE_LAST = LW'(BANDWIDTH - 1);
  localparam logic [LW-1:0]    LANE_ONE  = LW'(1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [NRW-1:0]   ROW_ONE   = NRW'(1);
  localparam logic [NRW-1:0]   ROW_ZERO  = NRW'(0);
  localparam logic [SW-1:0]    RND_C     = SW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] SAT_MAX = $signed({{(DW + 2){1'b0}}, {(DW - 1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = $signed({{(DW + 2){1'b1}}, {(DW - 1){1'b0}}});

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Round half up at one extra bit of headroom, then clamp to the DW-bit signed range.
  function automatic logic [DW-1:0] requant(input logic signed [2*DW-1:0] acc);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    logic [DW-1:0]        res;
    sum = $signed({acc[2*DW-1], acc}) + $signed(RND_C);
    shr = sum >>> FRAC_BITS;
    if (shr > SAT_MAX) begin
      res = SAT_MAX[DW-1:0];
    end else if (shr < SAT_MIN) begin
      res = SAT_MIN[DW-1:0];
    end else begin
      res = shr[DW-1:0];
    end
    return res;
  endfunction

  state_t                 state_q, state_d;
  logic [NRW-1:0]         num_rows_q, num_rows_d;
  logic [NRW-1:0]         rows_q, rows_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [DW*BW-1:0]       pack_q, pack_d;
  logic                   pend_q, pend_d;
  logic [CW-1:0]          pend_count_q, pend_count_d;
  logic                   pend_last_q, pend_last_d;
  logic                   final_drop_q, final_drop_d;
  logic [DW*BW-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [CW-1:0]          out_count_q, out_count_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic                   accept_s;
  logic                   last_row_s;
  logic                   out_hs_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_rows_q   <= '0;
      rows_q       <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      pend_q       <= 1'b0;
      pend_count_q <= '0;
      pend_last_q  <= 1'b0;
      final_drop_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_rows_q   <= num_rows_d;
      rows_q       <= rows_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
      pend_last_q  <= pend_last_d;
      final_drop_q <= final_drop_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state: chunk hand-off to the output register, lane packing and FSM control.
  always_comb begin
    state_d      = state_q;
    num_rows_d   = num_rows_q;
    rows_d       = rows_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    pend_d       = pend_q;
    pend_count_d = pend_count_q;
    pend_last_d  = pend_last_q;
    final_drop_d = final_drop_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;

    out_hs_s   = out_valid_q && out_ready;
    accept_s   = (state_q == ST_COLLECT) && result_valid && (rows_q < num_rows_q);
    last_row_s = (rows_q == (num_rows_q - ROW_ONE));

    if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // A chunk completed last edge: move it out, or drop it if the held word is unaccepted.
    if (pend_q) begin
      pend_d = 1'b0;
      pack_d = '0;
      if (!out_valid_q || out_ready) begin
        out_data_d  = pack_q;
        out_count_d = pend_count_q;
        out_last_d  = pend_last_q;
        out_valid_d = 1'b1;
      end else begin
        overflow_d   = 1'b1;
        final_drop_d = pend_last_q;
      end
      if (pend_last_q) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = state_q;
      end
    end else begin
      pend_d = 1'b0;
    end

    if (accept_s) begin
      pack_d[lane_q*DW +: DW] = requant(result_in);
      rows_d = rows_q + ROW_ONE;
      if ((lane_q == LANE_LAST) || last_row_s) begin
        pend_d       = 1'b1;
        pend_count_d = CW'(lane_q) + CNT_ONE;
        pend_last_d  = last_row_s;
        lane_d       = '0;
      end else begin
        lane_d = lane_q + LANE_ONE;
      end
    end else begin
      rows_d = rows_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_rows_d   = num_rows;
          rows_d       = '0;
          lane_d       = '0;
          pack_d       = '0;
          pend_d       = 1'b0;
          final_drop_d = 1'b0;
          overflow_d   = 1'b0;
          if (num_rows == ROW_ZERO) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_COLLECT;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        busy_d = 1'b1;
      end
      ST_DRAIN: begin
        if (final_drop_q || (out_hs_s && out_last_q)) begin
          done_d       = 1'b1;
          busy_d       = 1'b0;
          final_drop_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_count    = out_count_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_matvec_result_collector.sv
// Scoreboard bench for matvec_result_collector: expected packed words are queued
// when results are driven and compared at each output handshake.
module tb_matvec_result_collector;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [6:0]    num_rows;
  logic signed [31:0] result_in;
  logic          result_valid;
  logic [255:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_count;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overflow_err;

  matvec_result_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .result_in(result_in), .result_valid(result_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_last(out_last), .busy(busy), .done(done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    int           cnt;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  int           vals[64];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           cyc = 0;
  int           hs_cyc = 0;
  int           hs_cnt = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;
  logic [255:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_q(input longint x);
    longint t;
    t = (x + 64'sd2048) >>> 12;
    if (t > 64'sd32767) return 16'h7FFF;
    else if (t < -64'sd32768) return 16'h8000;
    else return t[15:0];
  endfunction

  function automatic exp_t chunk_word(input int c, input int n);
    exp_t e;
    e.d = '0;
    e.cnt = 0;
    for (int l = 0; l < 16 && c + l < n; l++) begin
      e.d[l*16 +: 16] = model_q(longint'(vals[c + l]));
      e.cnt++;
    end
    e.last = (c + 16 >= n);
    return e;
  endfunction

  task automatic push_words(input int n);
    for (int c = 0; c < n; c += 16) exp_q.push_back(chunk_word(c, n));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each handshake and records done pulses.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      hs_cnt++;
      hs_cyc = cyc;
      last_data = out_data;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 256'd1, 256'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("word_data", out_data, e.d);
        check_eq("word_count", 256'(out_count), 256'(e.cnt));
        check_eq("word_last", 256'(out_last), 256'(e.last));
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_op(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = 7'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      result_in = vals[i];
      result_valid = 1'b1;
      @(posedge clk); #1;
    end
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    int k;
    c0 = done_cnt;
    k = 0;
    while (done_cnt == c0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (done_cnt == c0) check_eq("done_timeout", 256'd0, 256'd1);
  endtask

  task automatic run_test1(input string tag);
    vals[0] = 4096; vals[1] = 8192; vals[2] = -4096; vals[3] = 2048;
    push_words(4);
    start_op(4);
    feed(0, 4);
    wait_done(50);
    check_eq({tag, "_done_lat"}, 256'(done_cyc - hs_cyc), 256'd1);
    check_eq({tag, "_lanes"}, last_data, 256'h0001_FFFF_0002_0001);
    check_eq({tag, "_sb_empty"}, 256'(exp_q.size()), 256'd0);
    check_eq({tag, "_busy_off"}, 256'(busy), 256'd0);
  endtask

  initial begin
    exp_t w1;
    int   hs0;
    int   d0;
    rst_n = 1'b0; start = 1'b0; num_rows = '0; result_in = '0;
    result_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", 256'(out_valid), 256'd0);
    check_eq("rst_out_data", out_data, 256'd0);
    check_eq("rst_out_count", 256'(out_count), 256'd0);
    check_eq("rst_busy", 256'(busy), 256'd0);
    check_eq("rst_done", 256'(done), 256'd0);
    check_eq("rst_overflow", 256'(overflow_err), 256'd0);

    // Test 1: basic rounding and packing.
    run_test1("t1");

    // Test 2: saturation both ways and negative half rounding.
    vals[0] = 32'h7FFF_FFFF; vals[1] = int'(32'h8000_0000); vals[2] = -6144;
    push_words(3);
    start_op(3);
    feed(0, 3);
    wait_done(50);
    check_eq("t2_sat_lanes", last_data, 256'hFFFF_8000_7FFF);

    // Test 3: two words, second partial.
    for (int i = 0; i < 20; i++) vals[i] = (i + 1) * 4096;
    hs0 = hs_cnt;
    push_words(20);
    start_op(20);
    feed(0, 20);
    wait_done(80);
    check_eq("t3_words", 256'(hs_cnt - hs0), 256'd2);
    check_eq("t3_sb_empty", 256'(exp_q.size()), 256'd0);

    // Test 4: full backpressure, later chunks dropped.
    for (int i = 0; i < 48; i++) vals[i] = (i + 1) * 4096;
    w1 = chunk_word(0, 48);
    exp_q.push_back(w1);
    out_ready = 1'b0;
    hs0 = hs_cnt;
    start_op(48);
    feed(0, 31);
    repeat (2) @(negedge clk);
    check_eq("t4_held_valid", 256'(out_valid), 256'd1);
    check_eq("t4_held_data", out_data, w1.d);
    check_eq("t4_no_ovf_yet", 256'(overflow_err), 256'd0);
    feed(31, 48);
    wait_done(80);
    check_eq("t4_overflow", 256'(overflow_err), 256'd1);
    check_eq("t4_still_data", out_data, w1.d);
    check_eq("t4_still_count", 256'(out_count), 256'd16);
    check_eq("t4_still_last", 256'(out_last), 256'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t4_one_word", 256'(hs_cnt - hs0), 256'd1);
    check_eq("t4_drained", 256'(out_valid), 256'd0);

    // Test 5: zero rows, then a start while busy.
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; num_rows = 7'd0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq("t5_zero_done", 256'(done), 256'd1);
    check_eq("t5_zero_valid", 256'(out_valid), 256'd0);
    check_eq("t5_zero_ovf_clr", 256'(overflow_err), 256'd0);
    @(negedge clk);
    check_eq("t5_done_pulse", 256'(done), 256'd0);
    check_eq("t5_done_once", 256'(done_cnt - d0), 256'd1);
    for (int i = 0; i < 4; i++) vals[i] = (i + 5) * 4096;
    hs0 = hs_cnt;
    push_words(4);
    start_op(4);
    start = 1'b1; num_rows = 7'd10;
    @(posedge clk); #1 start = 1'b0;
    feed(0, 4);
    wait_done(50);
    check_eq("t5_busy_start_words", 256'(hs_cnt - hs0), 256'd1);
    check_eq("t5_sb_empty", 256'(exp_q.size()), 256'd0);

    // Test 6: reset mid-collect, then a clean rerun.
    for (int i = 0; i < 4; i++) vals[i] = 4096;
    d0 = done_cnt;
    start_op(4);
    feed(0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_busy", 256'(busy), 256'd0);
    check_eq("t6_rst_valid", 256'(out_valid), 256'd0);
    check_eq("t6_rst_data", out_data, 256'd0);
    check_eq("t6_rst_count", 256'(out_count), 256'd0);
    check_eq("t6_rst_last", 256'(out_last), 256'd0);
    check_eq("t6_rst_done", 256'(done), 256'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_done", 256'(done_cnt - d0), 256'd0);
    run_test1("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
